// File: rtl/io_port_responder_if.sv
// Handshake/bus bundle between the control unit + board I/O (master) and the
// IN/OUT port responder (slave).
interface io_port_responder_if #(
  parameter int DATA_W = 32,
  parameter int SW_W   = 16
);
  logic              in_req;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SW_W-1:0]   sw;
  logic              enter_btn;
  logic              new_out;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] display;
  logic              out_strobe;
  logic              waiting;
  logic              wake_up;

  modport master (
    output in_req, sw, enter_btn, new_out, out_data,
    input  in_ready, in_data, display, out_strobe, waiting, wake_up
  );

  modport slave (
    input  in_req, sw, enter_btn, new_out, out_data,
    output in_ready, in_data, display, out_strobe, waiting, wake_up
  );
endinterface

// File: rtl/io_port_responder.sv
// Peripheral end of the IN/OUT handshake: debounced enter button, switch capture,
// OUT display latch and HALT wake-up. Define IN_SIGN_EXT_EN to sign-extend sw.
module io_port_responder #(
  parameter int DATA_W          = 32,
  parameter int SW_W            = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  io_port_responder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, READY} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_sync1, r_sync2, r_deb, r_press;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_settle;
  logic              w_capture, w_wake;
  logic [DATA_W-1:0] w_sw_ext;
  logic [DATA_W-1:0] r_in_data;
  logic [DATA_W-1:0] r_display;
  logic              r_out_strobe;

  // Level flips on the cycle the counter has already seen DEBOUNCE_CYCLES mismatches.
  assign w_settle = (r_sync2 != r_deb) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_deb   <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= bus.enter_btn;
      r_sync2 <= r_sync1;
      r_press <= w_settle && r_sync2;
      if (r_sync2 == r_deb) begin
        r_cnt <= '0;
      end else if (w_settle) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
`ifdef IN_SIGN_EXT_EN
    w_sw_ext = {DATA_W{bus.sw[SW_W-1]}};
`else
    w_sw_ext = '0;
`endif
    w_sw_ext[SW_W-1:0] = bus.sw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_wake      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_wake = r_press;
        if (bus.in_req) w_state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (r_press) begin
          w_capture   = 1'b1;
          w_state_nxt = READY;
        end else if (!bus.in_req) begin
          w_state_nxt = IDLE;
        end
      end
      READY: begin
        if (!bus.in_req) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_data    <= '0;
      r_display    <= '0;
      r_out_strobe <= 1'b0;
    end else begin
      if (w_capture) r_in_data <= w_sw_ext;
      if (bus.new_out) r_display <= bus.out_data;
      r_out_strobe <= bus.new_out;
    end
  end

  assign bus.in_ready   = (r_state == READY);
  assign bus.waiting    = (r_state == WAIT_PRESS);
  assign bus.wake_up    = w_wake;
  assign bus.in_data    = r_in_data;
  assign bus.display    = r_display;
  assign bus.out_strobe = r_out_strobe;

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Peripheral-side end of the processor's IN/OUT handshake; sits between the control unit/datapath and board switches, push-button and display.
- Answers the control unit's in_req by waiting for a debounced "enter" press, then returns the switch value with in_ready.
- Latches OUT data on new_out and produces the wake_up pulse that releases the control unit from HALT.

Parameters:
- DATA_W, 32, width of the processor data word (in_data, out_data, display).
- SW_W, 16, number of board switches; must satisfy SW_W <= DATA_W.
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced button level changes; must be >= 1.
- CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_req  in  1  input request from control unit; high for the whole input-wait state.
- in_ready  out  1  input data valid for the control unit.
- in_data  out  DATA_W  value returned to the datapath for IN.
- sw  in  SW_W  raw switch levels; quasi-static, not synchronized.
- enter_btn  in  1  raw push-button, active-high, asynchronous, bouncy.
- new_out  in  1  OUT write strobe from control unit.
- out_data  in  DATA_W  OUT operand from datapath.
- display  out  DATA_W  last OUT value.
- out_strobe  out  1  one-cycle pulse after each display update.
- waiting  out  1  high while waiting for the operator (LED).
- wake_up  out  1  one-cycle pulse to leave HALT.

Behaviour:
- Reset (asynchronous, rst_n low): all outputs 0; FSM in IDLE; synchronizer flops, debounced level and debounce counter at 0.
- Button conditioning:
  - enter_btn passes through a 2-flop synchronizer.
  - Counter increments each cycle the synchronized value differs from the debounced level, and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronized value and the counter clears.
  - press is a registered one-cycle pulse on each debounced 0->1 transition.
  - A second press requires a debounced release in between; holding the button gives exactly one press.
- FSM states: IDLE, WAIT_PRESS, READY.
  - IDLE -> WAIT_PRESS: in_req=1.
  - IDLE with press: wake_up=1 for that one cycle; press is then consumed.
  - WAIT_PRESS: waiting=1.
    - press: in_data <= sw zero-extended to DATA_W; in_ready <= 1; go to READY.
    - in_req falls before any press: return to IDLE, in_data unchanged, no wake_up.
  - READY: in_ready held at 1 and in_data held stable.
    - Leave READY on the first posedge with in_req=0: in_ready <= 0; go to IDLE.
    - A press while in READY is ignored.
  - press and in_req rising in the same cycle while in IDLE: treated as wake_up only; the FSM enters WAIT_PRESS and needs a new press.
- in_data persists after READY until the next capture; the datapath writes it during the state after input-wait.
- Latency: raw enter_btn first sampled high at posedge k and held clean; in_ready is high after posedge k+DEBOUNCE_CYCLES+3.
- Output path (independent of the FSM):
  - Every posedge with new_out=1: display <= out_data; out_strobe=1 the following cycle.
  - new_out high on consecutive cycles updates display each cycle.
- Simultaneous input and output activity is legal; the two paths share no state.
- rst_n asserted mid-handshake drops in_ready immediately (asynchronous).

Optional Feature:
- Macro: IN_SIGN_EXT_EN.
- Defined: captured sw is sign-extended from bit SW_W-1 to DATA_W.
- Undefined: captured sw is zero-extended.
- No other behaviour changes.

Test Plan:
- Bench setup: DEBOUNCE_CYCLES=4, SW_W=16, DATA_W=32.
- Basic IN: in_req=1, sw=16'h00A5, clean press -> waiting=1 until in_ready=1 after exactly 7 posedges, in_data=32'h000000A5. Drop in_req -> in_ready=0 next posedge; in_data stays 32'h000000A5.
- Bounce rejection: in WAIT_PRESS, toggle enter_btn every 2 cycles for 20 cycles, then hold high -> no in_ready during bouncing, exactly one capture after the stable hold. Hold 100 cycles -> no second capture.
- OUT: new_out=1 for one cycle with out_data=32'hDEADBEEF -> display=32'hDEADBEEF and a single out_strobe pulse. Display unchanged afterwards.
- HALT wake: in_req=0, clean press -> wake_up high for exactly one cycle, in_ready stays 0. With in_req=1 and no press -> wake_up never asserts.
- Reset mid-handshake: in READY, pulse rst_n low -> in_ready, in_data and display read 0 immediately. After release, FSM in IDLE (waiting=0 with in_req=0).
- Sign-extend build (IN_SIGN_EXT_EN defined): sw=16'h8001 -> in_data=32'hFFFF8001; same stimulus without the macro -> 32'h00008001.
